// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: synchronises request lines, latches pending bits, and hands the
// lowest-index eligible id to the PC sequencer. Define IRQ_EDGE_EN for rising-edge pending capture.
module irq_ctrl #(
   parameter int          NUM_IRQ      = 8,
   parameter logic [11:0] VECTOR_BASE  = 12'h004,
   parameter int          VECTOR_SHIFT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               pause,
   input  logic               stack_full,
   input  logic               int_ack,
   input  logic               reti,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [7:0]         cfg_wdata,
   output logic [7:0]         cfg_rdata,
   output logic               int_req,
   output logic [11:0]        int_vector,
   output logic               in_isr,
   output logic [2:0]         active_id
);

   typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

   state_t             state, state_nxt;
   logic [NUM_IRQ-1:0] sync_p0, sync_p1;
   logic [NUM_IRQ-1:0] mask, pend, pend_nxt, pend_set, w1c, elig;
   logic               gie;
   logic [2:0]         winner;
   logic [11:0]        vector_nxt;
   logic               dispatch, ack_take, reti_take;

   // Stage p0/p1: two-flop synchroniser on the asynchronous request lines
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= irq_in;
         sync_p1 <= sync_p0;
      end
   end

`ifdef IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] sync_prev;

   always_ff @(posedge clk) begin
      if (reset) sync_prev <= '0;
      else       sync_prev <= sync_p1;
   end

   assign pend_set = sync_p1 & ~sync_prev;
`else
   assign pend_set = sync_p1;
`endif

   assign elig      = pend & mask;
   assign ack_take  = (state == REQ) && int_ack;
   assign reti_take = (state == ACTIVE) && reti;
   assign dispatch  = (state == IDLE) && (|elig) && gie && !pause && !stack_full;

   always_comb begin
      winner = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (elig[i]) winner = 3'(i);
      end
   end

   assign vector_nxt = VECTOR_BASE + (12'(winner) << VECTOR_SHIFT);

   // A new set outranks a W1C, but the ack clear of the serviced id outranks everything
   always_comb begin
      w1c      = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_IRQ-1:0] : '0;
      pend_nxt = (pend & ~w1c) | pend_set;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (ack_take && active_id == 3'(i)) pend_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (dispatch)  state_nxt = REQ;
         REQ:     if (ack_take)  state_nxt = ACTIVE;
         ACTIVE:  if (reti_take) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask       <= '0;
         pend       <= '0;
         gie        <= 1'b0;
         active_id  <= 3'd0;
         int_vector <= 12'd0;
      end else begin
         pend <= pend_nxt;
         if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata[NUM_IRQ-1:0];
         if (reti_take)                       gie <= 1'b1;
         else if (ack_take)                   gie <= 1'b0;
         else if (cfg_we && cfg_addr == 2'd2) gie <= cfg_wdata[0];
         if (dispatch) begin
            active_id  <= winner;
            int_vector <= vector_nxt;
         end
      end
   end

   assign int_req = (state == REQ);
   assign in_isr  = (state == ACTIVE);

   always_comb begin
      cfg_rdata = 8'd0;
      unique case (cfg_addr)
         2'd0: cfg_rdata[NUM_IRQ-1:0] = mask;
         2'd1: cfg_rdata[NUM_IRQ-1:0] = pend;
         2'd2: cfg_rdata[0]           = gie;
         2'd3: cfg_rdata              = {3'b000, in_isr, int_req, active_id};
         default: cfg_rdata = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus a randomized run against a history-based reference model.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_in = 8'd0;
   logic        pause = 1'b0, stack_full = 1'b0, int_ack = 1'b0, reti = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [7:0]  cfg_wdata = 8'd0;
   logic [7:0]  cfg_rdata;
   logic        int_req, in_isr;
   logic [11:0] int_vector;
   logic [2:0]  active_id;

   int tests = 0;
   int fails = 0;

   // Reference model: phase 0=idle, 1=requesting, 2=in ISR; m_h[n] = irq_in seen n+1 edges ago
   int m_phase = 0, m_id = 0, m_pend = 0, m_mask = 0, m_gie = 0;
   int m_h[3] = '{0, 0, 0};

   irq_ctrl dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .pause(pause), .stack_full(stack_full),
      .int_ack(int_ack), .reti(reti), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .int_req(int_req),
      .int_vector(int_vector), .in_isr(in_isr), .active_id(active_id)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input int v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic tick();
      int set_v, np, nid, npend, ngie, nmask, elig, clr;
      int nh[3];
      if (reset) begin
         np = 0; nid = 0; npend = 0; ngie = 0; nmask = 0;
         nh = '{0, 0, 0};
      end else begin
`ifdef IRQ_EDGE_EN
         set_v = m_h[1] & ~m_h[2];
`else
         set_v = m_h[1];
`endif
         np = m_phase; nid = m_id; nmask = m_mask; ngie = m_gie;
         if (cfg_we && cfg_addr == 2'd0) nmask = int'(cfg_wdata);
         if (cfg_we && cfg_addr == 2'd2) ngie = int'(cfg_wdata[0]);
         clr = (cfg_we && cfg_addr == 2'd1) ? int'(cfg_wdata) : 0;
         npend = (m_pend & ~clr) | set_v;
         elig = m_pend & m_mask;
         if (m_phase == 0 && elig != 0 && m_gie != 0 && !pause && !stack_full) begin
            np = 1; nid = lowest(elig);
         end else if (m_phase == 1 && int_ack) begin
            np = 2; ngie = 0; npend = npend & ~(1 << m_id);
         end else if (m_phase == 2 && reti) begin
            np = 0; ngie = 1;
         end
         nh[2] = m_h[1]; nh[1] = m_h[0]; nh[0] = int'(irq_in);
      end
      @(posedge clk);
      #1;
      m_phase = np; m_id = nid; m_pend = npend & 8'hFF; m_mask = nmask; m_gie = ngie;
      m_h = nh;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse(input logic [7:0] lines);
      irq_in = lines;
      tick();
      irq_in = 8'd0;
   endtask

   task automatic do_ack();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
   endtask

   task automatic do_reti();
      reti = 1'b1; tick(); reti = 1'b0;
   endtask

   task automatic wait_req(input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < limit; n++) begin
         if (int_req) begin ok = 1'b1; break; end
         tick();
      end
      if (int_req) ok = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      tests++;
      if (int_req !== 1'b0 || in_isr !== 1'b0 || active_id !== 3'd0 || int_vector !== 12'd0) begin
         fails++;
         $display("FAIL reset_outputs: req=%0b isr=%0b id=%0d vec=%h required 0/0/0/000",
                  int_req, in_isr, active_id, int_vector);
      end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         tests++;
         if (d !== 8'd0) begin fails++; $display("FAIL reset_reg%0d: read %h required 00", a, d); end
      end
   endtask

   task automatic test_basic_dispatch();
      logic [7:0] d;
      wr(2'd0, 8'h05); wr(2'd2, 8'h01);
      pulse(8'h04);
      tests++;
      if (int_req !== 1'b0) begin fails++; $display("FAIL t1_early_k: int_req=%0b required 0", int_req); end
      tick(); tick();
      rd(2'd1, d);
      tests++;
      if (d !== 8'h04 || int_req !== 1'b0) begin
         fails++; $display("FAIL t1_pend_k2: pend=%h req=%0b required 04/0", d, int_req);
      end
      tick();
      tests++;
      if (int_req !== 1'b1 || int_vector !== 12'h008 || active_id !== 3'd2) begin
         fails++; $display("FAIL t1_req: req=%0b vec=%h id=%0d required 1/008/2", int_req, int_vector, active_id);
      end
      rd(2'd3, d);
      tests++;
      if (d !== 8'h0A) begin fails++; $display("FAIL t1_status: read %h required 0a", d); end
      do_ack();
      tests++;
      if (in_isr !== 1'b1 || int_req !== 1'b0) begin
         fails++; $display("FAIL t1_ack: isr=%0b req=%0b required 1/0", in_isr, int_req);
      end
      rd(2'd1, d);
      tests++;
      if (d !== 8'h00) begin fails++; $display("FAIL t1_pend_clr: read %h required 00", d); end
      rd(2'd2, d);
      tests++;
      if (d !== 8'h00) begin fails++; $display("FAIL t1_ctrl_ack: read %h required 00", d); end
      do_reti();
      rd(2'd2, d);
      tests++;
      if (in_isr !== 1'b0 || d !== 8'h01) begin
         fails++; $display("FAIL t1_reti: isr=%0b ctrl=%h required 0/01", in_isr, d);
      end
   endtask

   task automatic test_priority();
      bit ok;
      logic [7:0] d;
      wr(2'd0, 8'hFF);
      pulse(8'h05);
      wait_req(10, ok);
      tests++;
      if (!ok || int_vector !== 12'h004 || active_id !== 3'd0) begin
         fails++; $display("FAIL t2_first: req=%0b vec=%h required 1/004", int_req, int_vector);
      end
      do_ack();
      rd(2'd1, d);
      tests++;
      if (d !== 8'h04) begin fails++; $display("FAIL t2_pend: read %h required 04", d); end
      do_reti();
      tests++;
      if (int_req !== 1'b0) begin fails++; $display("FAIL t2_gap: int_req=%0b required 0", int_req); end
      tick();
      tests++;
      if (int_req !== 1'b1 || int_vector !== 12'h008) begin
         fails++; $display("FAIL t2_second: req=%0b vec=%h required 1/008", int_req, int_vector);
      end
      do_ack(); do_reti();
   endtask

   task automatic test_active_block();
      bit ok, saw;
      logic [7:0] d;
      pulse(8'h01);
      wait_req(10, ok);
      do_ack();
      pulse(8'h02);
      saw = 1'b0;
      repeat (5) begin tick(); if (int_req) saw = 1'b1; end
      rd(2'd1, d);
      tests++;
      if (!ok || saw || d !== 8'h02) begin
         fails++; $display("FAIL t3_accum: first_ok=%0b req_seen=%0b pend=%h required 1/0/02", ok, saw, d);
      end
      do_reti();
      tests++;
      if (int_req !== 1'b0 || in_isr !== 1'b0) begin
         fails++; $display("FAIL t3_ret: req=%0b isr=%0b required 0/0", int_req, in_isr);
      end
      tick();
      tests++;
      if (int_req !== 1'b1 || int_vector !== 12'h006) begin
         fails++; $display("FAIL t3_redispatch: req=%0b vec=%h required 1/006", int_req, int_vector);
      end
      do_ack(); do_reti();
   endtask

   task automatic test_blocking();
      bit saw;
      stack_full = 1'b1;
      pulse(8'h08);
      saw = 1'b0;
      repeat (20) begin tick(); if (int_req) saw = 1'b1; end
      tests++;
      if (saw) begin fails++; $display("FAIL t4_stack_full: int_req seen=1 required 0"); end
      stack_full = 1'b0;
      tick();
      tests++;
      if (int_req !== 1'b1 || int_vector !== 12'h00A) begin
         fails++; $display("FAIL t4_stack_release: req=%0b vec=%h required 1/00a", int_req, int_vector);
      end
      do_ack(); do_reti();
      pause = 1'b1;
      pulse(8'h10);
      saw = 1'b0;
      repeat (10) begin tick(); if (int_req) saw = 1'b1; end
      tests++;
      if (saw) begin fails++; $display("FAIL t4_pause: int_req seen=1 required 0"); end
      pause = 1'b0;
      tick();
      tests++;
      if (int_req !== 1'b1 || int_vector !== 12'h00C) begin
         fails++; $display("FAIL t4_pause_release: req=%0b vec=%h required 1/00c", int_req, int_vector);
      end
      do_ack(); do_reti();
   endtask

   task automatic test_w1c_and_hold();
      logic [7:0] d;
      int n_ack;
      wr(2'd2, 8'h00);
      pulse(8'h08);
      tick();
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h08;
      tick();
      cfg_we = 1'b0;
      rd(2'd1, d);
      tests++;
      if (d !== 8'h08) begin fails++; $display("FAIL t5_set_beats_w1c: pend=%h required 08", d); end
      wr(2'd1, 8'h08);
      rd(2'd1, d);
      tests++;
      if (d !== 8'h00) begin fails++; $display("FAIL t5_w1c: pend=%h required 00", d); end
      wr(2'd2, 8'h01);
      irq_in = 8'h08;
      n_ack = 0;
      repeat (50) begin
         if (int_req) begin int_ack = 1'b1; n_ack++; end
         else if (in_isr) reti = 1'b1;
         tick();
         int_ack = 1'b0; reti = 1'b0;
      end
      irq_in = 8'h00;
      tests++;
`ifdef IRQ_EDGE_EN
      if (n_ack != 1) begin fails++; $display("FAIL t5_hold_edge: dispatches=%0d required 1", n_ack); end
`else
      if (n_ack < 2) begin fails++; $display("FAIL t5_hold_level: dispatches=%0d required >=2", n_ack); end
`endif
      repeat (30) begin
         if (int_req) int_ack = 1'b1;
         else if (in_isr) reti = 1'b1;
         tick();
         int_ack = 1'b0; reti = 1'b0;
      end
      rd(2'd1, d);
      tests++;
      if (int_req !== 1'b0 || in_isr !== 1'b0 || d !== 8'h00) begin
         fails++; $display("FAIL t5_drain: req=%0b isr=%0b pend=%h required 0/0/00", int_req, in_isr, d);
      end
   endtask

   task automatic test_reset_in_req();
      bit ok;
      logic [7:0] d0, d1, d2;
      pulse(8'h01);
      wait_req(10, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL t6_reach_req: int_req=%0b required 1", int_req); end
      reset = 1'b1; tick(); reset = 1'b0;
      rd(2'd0, d0); rd(2'd1, d1); rd(2'd2, d2);
      tests++;
      if (int_req !== 1'b0 || in_isr !== 1'b0 || d0 !== 8'h00 || d1 !== 8'h00 || d2 !== 8'h00) begin
         fails++;
         $display("FAIL t6_reset: req=%0b isr=%0b mask=%h pend=%h ctrl=%h required all 0",
                  int_req, in_isr, d0, d1, d2);
      end
   endtask

   task automatic test_random();
      int nprint = 0;
      bit bad;
      int r;
      wr(2'd0, 8'($urandom_range(1, 255)));
      wr(2'd2, 8'h01);
      cfg_addr = 2'd1;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) irq_in[b] = ~irq_in[b];
         pause      = ($urandom_range(0, 4) == 0);
         stack_full = ($urandom_range(0, 5) == 0);
         int_ack    = (int_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
         reti       = (in_isr && $urandom_range(0, 3) == 0) || ($urandom_range(0, 19) == 0);
         r = $urandom_range(0, 29);
         cfg_we = (r < 2);
         cfg_addr = (r == 0) ? 2'd0 : 2'd1;
         cfg_wdata = 8'($urandom);
         tick();
         cfg_we = 1'b0; cfg_addr = 2'd1;
         #1;
         bad = (int_req !== (m_phase == 1)) || (in_isr !== (m_phase == 2)) ||
               (cfg_rdata !== 8'(m_pend)) ||
               (m_phase != 0 && active_id !== 3'(m_id)) ||
               (m_phase == 1 && int_vector !== 12'(4 + 2 * m_id));
         tests++;
         if (bad) begin
            fails++;
            if (nprint < 8) begin
               nprint++;
               $display("FAIL rand_cyc%0d: req=%0b isr=%0b id=%0d vec=%h pend=%h required phase=%0d id=%0d vec=%h pend=%h",
                        cyc, int_req, in_isr, active_id, int_vector, cfg_rdata,
                        m_phase, m_id, 12'(4 + 2 * m_id), 8'(m_pend));
            end
         end
      end
      irq_in = 8'd0; pause = 1'b0; stack_full = 1'b0; int_ack = 1'b0; reti = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic_dispatch();
      test_priority();
      test_active_block();
      test_blocking();
      test_w1c_and_hold();
      test_reset_in_req();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
